// File: rtl/dcache_controller.sv
// Direct-mapped write-through data cache for the M stage.
// 16 lines x 4 words, one-entry write buffer, block refill.
module dcache_controller (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         MemtoRegM,
  input  logic         MemWriteM,
  input  logic [31:0]  ALUOutM,
  input  logic [31:0]  WriteDataM,
  output logic         hit,
  output logic [31:0]  ReadDataM,
  output logic         FillDone,
  output logic         Busy,
  output logic         MemReq,
  output logic         MemWE,
  output logic [31:0]  MemAddr,
  output logic [31:0]  MemWData,
  input  logic [127:0] MemRData,
  input  logic         MemReady
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WB,
    FILL,
    RESP
  } state_t;

  state_t state, stateNext;

  logic [31:0] dataArr [16][4];
  logic [23:0] tagArr  [16];
  logic [15:0] validArr;

  logic        wbValid;
  logic [31:0] wbAddr;
  logic [31:0] wbData;
  logic [31:0] reqAddr;
  logic [31:0] reqData;

  logic [3:0]  mIdx;
  logic [1:0]  mOff;
  logic        mHit;
  logic [3:0]  cIdx;
  logic [1:0]  cOff;
  logic        cHit;
  logic        drain;

  logic        capture;
  logic        wbLoad;
  logic [31:0] wbLoadAddr;
  logic [31:0] wbLoadData;
  logic        wordWr;
  logic [31:0] wrAddr;
  logic [31:0] wrData;
  logic        fillWr;

  assign mIdx  = ALUOutM[7:4];
  assign mOff  = ALUOutM[3:2];
  assign mHit  = validArr[mIdx]
               && (tagArr[mIdx] == ALUOutM[31:8]);
  assign cIdx  = reqAddr[7:4];
  assign cOff  = reqAddr[3:2];
  assign cHit  = validArr[cIdx]
               && (tagArr[cIdx] == reqAddr[31:8]);
  assign drain = wbValid && MemReady;

  assign Busy  = CLR && (state != IDLE);

  always_comb begin
    stateNext  = state;
    hit        = 1'b0;
    ReadDataM  = '0;
    FillDone   = 1'b0;
    capture    = 1'b0;
    wbLoad     = 1'b0;
    wbLoadAddr = ALUOutM;
    wbLoadData = WriteDataM;
    wordWr     = 1'b0;
    wrAddr     = ALUOutM;
    wrData     = WriteDataM;
    fillWr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemtoRegM) begin
          if (mHit) begin
            hit       = 1'b1;
            ReadDataM = dataArr[mIdx][mOff];
          end else begin
            capture   = 1'b1;
            stateNext = FILL;
          end
        end else if (MemWriteM) begin
          // acceptance looks only at the buffer state at cycle start
          if (!wbValid) begin
            hit    = 1'b1;
            wbLoad = 1'b1;
            wordWr = mHit;
          end else begin
            capture   = 1'b1;
            stateNext = WAIT_WB;
          end
        end
      end
      WAIT_WB: begin
        if (drain) begin
          wbLoad     = 1'b1;
          wbLoadAddr = reqAddr;
          wbLoadData = reqData;
          wordWr     = cHit;
          wrAddr     = reqAddr;
          wrData     = reqData;
          stateNext  = IDLE;
        end
      end
      FILL: begin
        if (!wbValid && MemReady) begin
          fillWr    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        FillDone  = 1'b1;
        ReadDataM = dataArr[cIdx][cOff];
        stateNext = IDLE;
      end
    endcase
    if (!CLR) begin
      hit       = 1'b0;
      ReadDataM = '0;
      FillDone  = 1'b0;
    end
  end

  // buffered write always wins the memory port over a refill
  always_comb begin
    MemReq   = 1'b0;
    MemWE    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    if (CLR) begin
      if (wbValid) begin
        MemReq   = 1'b1;
        MemWE    = 1'b1;
        MemAddr  = wbAddr;
        MemWData = wbData;
      end else if (state == FILL) begin
        MemReq  = 1'b1;
        MemAddr = {reqAddr[31:4], 4'b0000};
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= IDLE;
      validArr <= '0;
      wbValid  <= 1'b0;
      wbAddr   <= '0;
      wbData   <= '0;
      reqAddr  <= '0;
      reqData  <= '0;
    end else begin
      state <= stateNext;
      if (capture) begin
        reqAddr <= ALUOutM;
        reqData <= WriteDataM;
      end
      if (wbLoad) begin
        wbValid <= 1'b1;
        wbAddr  <= wbLoadAddr;
        wbData  <= wbLoadData;
      end else if (drain) begin
        wbValid <= 1'b0;
      end
      if (fillWr) begin
        validArr[cIdx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fillWr) begin
      dataArr[cIdx][0] <= MemRData[31:0];
      dataArr[cIdx][1] <= MemRData[63:32];
      dataArr[cIdx][2] <= MemRData[95:64];
      dataArr[cIdx][3] <= MemRData[127:96];
      tagArr[cIdx]     <= reqAddr[31:8];
    end else if (wordWr) begin
      dataArr[wrAddr[7:4]][wrAddr[3:2]] <= wrData;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: refill, hits,
// write buffer draining and asynchronous reset.
module tb_dcache_controller;

  logic         CLK;
  logic         CLR;
  logic         MemtoRegM;
  logic         MemWriteM;
  logic [31:0]  ALUOutM;
  logic [31:0]  WriteDataM;
  logic         hit;
  logic [31:0]  ReadDataM;
  logic         FillDone;
  logic         Busy;
  logic         MemReq;
  logic         MemWE;
  logic [31:0]  MemAddr;
  logic [31:0]  MemWData;
  logic [127:0] MemRData;
  logic         MemReady;

  int nCmp = 0;
  int nErr = 0;

  dcache_controller dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .hit        (hit),
    .ReadDataM  (ReadDataM),
    .FillDone   (FillDone),
    .Busy       (Busy),
    .MemReq     (MemReq),
    .MemWE      (MemWE),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .MemReady   (MemReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    MemtoRegM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    MemtoRegM = 1'b1;
    MemWriteM = 1'b0;
    ALUOutM   = a;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    MemtoRegM  = 1'b0;
    MemWriteM  = 1'b1;
    ALUOutM    = a;
    WriteDataM = d;
  endtask

  initial begin
    CLR        = 1'b0;
    MemReady   = 1'b0;
    MemRData   = '0;
    WriteDataM = '0;
    store(32'h104, 32'h5555_5555);
    #3;
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_memreq", {31'b0, MemReq}, 32'd0);
    chk("rst_memwe", {31'b0, MemWE}, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_filldone", {31'b0, FillDone}, 32'd0);
    cyc();
    cyc();
    idle();
    CLR = 1'b1;

    // cold miss and refill of 0x104
    cyc();
    load(32'h104);
    #2;
    chk("miss_hit", {31'b0, hit}, 32'd0);
    chk("miss_busy0", {31'b0, Busy}, 32'd0);
    cyc();
    idle();
    #2;
    chk("fill_busy", {31'b0, Busy}, 32'd1);
    chk("fill_req1", {31'b0, MemReq}, 32'd1);
    chk("fill_we", {31'b0, MemWE}, 32'd0);
    chk("fill_addr", MemAddr, 32'h100);
    cyc();
    cyc();
    #2;
    chk("fill_req3", {31'b0, MemReq}, 32'd1);
    cyc();
    MemReady = 1'b1;
    MemRData = {32'h3333_3333, 32'h2222_2222,
                32'hCAFE_F00D, 32'h1111_1111};
    #2;
    chk("fill_req4", {31'b0, MemReq}, 32'd1);
    chk("fill_nodone", {31'b0, FillDone}, 32'd0);
    cyc();
    MemReady = 1'b0;
    #2;
    chk("resp_done", {31'b0, FillDone}, 32'd1);
    chk("resp_data", ReadDataM, 32'hCAFE_F00D);
    chk("resp_req", {31'b0, MemReq}, 32'd0);
    cyc();
    #2;
    chk("post_busy", {31'b0, Busy}, 32'd0);
    chk("post_done", {31'b0, FillDone}, 32'd0);

    // hits on the filled line
    cyc();
    load(32'h104);
    #2;
    chk("hit104", {31'b0, hit}, 32'd1);
    chk("hit104_d", ReadDataM, 32'hCAFE_F00D);
    chk("hit104_req", {31'b0, MemReq}, 32'd0);
    cyc();
    load(32'h10C);
    #2;
    chk("hit10c_d", ReadDataM, 32'h3333_3333);
    cyc();
    load(32'h100);
    #2;
    chk("hit100_d", ReadDataM, 32'h1111_1111);
    cyc();
    idle();
    #2;
    chk("noreq_hit", {31'b0, hit}, 32'd0);
    chk("noreq_data", ReadDataM, 32'd0);

    // store hit with empty buffer
    cyc();
    store(32'h104, 32'h1234_5678);
    #2;
    chk("st_hit", {31'b0, hit}, 32'd1);
    chk("st_busy", {31'b0, Busy}, 32'd0);
    cyc();
    load(32'h104);
    MemReady = 1'b1;
    #2;
    chk("wb_req", {31'b0, MemReq}, 32'd1);
    chk("wb_we", {31'b0, MemWE}, 32'd1);
    chk("wb_addr", MemAddr, 32'h104);
    chk("wb_wdata", MemWData, 32'h1234_5678);
    chk("st_ld_hit", {31'b0, hit}, 32'd1);
    chk("st_ld_d", ReadDataM, 32'h1234_5678);
    cyc();
    idle();
    MemReady = 1'b0;
    #2;
    chk("wb_drained", {31'b0, MemReq}, 32'd0);

    // back-to-back stores, slow memory
    cyc();
    store(32'h200, 32'hAAAA_0001);
    #2;
    chk("bb1_hit", {31'b0, hit}, 32'd1);
    cyc();
    store(32'h108, 32'hBBBB_0002);
    #2;
    chk("bb2_hit", {31'b0, hit}, 32'd0);
    chk("bb2_addr", MemAddr, 32'h200);
    cyc();
    idle();
    #2;
    chk("bb_busy1", {31'b0, Busy}, 32'd1);
    chk("bb_hitbusy", {31'b0, hit}, 32'd0);
    cyc();
    store(32'h10C, 32'hDEAD_DEAD);
    #2;
    chk("bb_busy2", {31'b0, Busy}, 32'd1);
    chk("bb_ignore", {31'b0, hit}, 32'd0);
    cyc();
    idle();
    MemReady = 1'b1;
    #2;
    chk("bb_addr1", MemAddr, 32'h200);
    chk("bb_wd1", MemWData, 32'hAAAA_0001);
    cyc();
    MemReady = 1'b0;
    #2;
    chk("bb_idle", {31'b0, Busy}, 32'd0);
    chk("bb_req2", {31'b0, MemReq}, 32'd1);
    chk("bb_addr2", MemAddr, 32'h108);
    chk("bb_wd2", MemWData, 32'hBBBB_0002);
    cyc();
    MemReady = 1'b1;
    cyc();
    MemReady = 1'b0;
    #2;
    chk("bb_done", {31'b0, MemReq}, 32'd0);
    cyc();
    load(32'h108);
    #2;
    chk("bb_ld108", ReadDataM, 32'hBBBB_0002);
    cyc();
    load(32'h10C);
    #2;
    chk("bb_ld10c", ReadDataM, 32'h3333_3333);

    // load miss behind a buffered write
    cyc();
    store(32'h300, 32'hDDDD_0004);
    #2;
    chk("lm_st_hit", {31'b0, hit}, 32'd1);
    cyc();
    load(32'h204);
    #2;
    chk("lm_hit", {31'b0, hit}, 32'd0);
    chk("lm_we1", {31'b0, MemWE}, 32'd1);
    cyc();
    idle();
    MemReady = 1'b1;
    #2;
    chk("lm_busy", {31'b0, Busy}, 32'd1);
    chk("lm_we2", {31'b0, MemWE}, 32'd1);
    chk("lm_waddr", MemAddr, 32'h300);
    cyc();
    MemRData = {32'h4343_4343, 32'h4242_4242,
                32'h4141_4141, 32'h4040_4040};
    #2;
    chk("lm_rd_req", {31'b0, MemReq}, 32'd1);
    chk("lm_rd_we", {31'b0, MemWE}, 32'd0);
    chk("lm_rd_addr", MemAddr, 32'h200);
    chk("lm_nodone", {31'b0, FillDone}, 32'd0);
    cyc();
    MemReady = 1'b0;
    #2;
    chk("lm_done", {31'b0, FillDone}, 32'd1);
    chk("lm_data", ReadDataM, 32'h4141_4141);
    cyc();
    load(32'h20C);
    #2;
    chk("lm_hit20c", ReadDataM, 32'h4343_4343);
    cyc();
    load(32'h104);
    #2;
    chk("lm_evict", {31'b0, hit}, 32'd0);

    // drop that refill via reset; also reset mid-fill
    cyc();
    idle();
    #2;
    chk("rf_req", {31'b0, MemReq}, 32'd1);
    CLR = 1'b0;
    load(32'h208);
    #1;
    chk("ar_busy", {31'b0, Busy}, 32'd0);
    chk("ar_req", {31'b0, MemReq}, 32'd0);
    chk("ar_we", {31'b0, MemWE}, 32'd0);
    chk("ar_hit", {31'b0, hit}, 32'd0);
    chk("ar_data", ReadDataM, 32'd0);
    chk("ar_done", {31'b0, FillDone}, 32'd0);
    cyc();
    idle();
    CLR = 1'b1;
    cyc();
    MemReady = 1'b1;
    #2;
    chk("late_busy", {31'b0, Busy}, 32'd0);
    chk("late_req", {31'b0, MemReq}, 32'd0);
    cyc();
    MemReady = 1'b0;
    #2;
    chk("late_done", {31'b0, FillDone}, 32'd0);
    chk("late_busy2", {31'b0, Busy}, 32'd0);
    cyc();
    load(32'h208);
    #2;
    chk("post_rst_miss", {31'b0, hit}, 32'd0);
    cyc();
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: CLR  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: MemtoRegM  in  1  M-stage load request; MemWriteM  in  1  M-stage store request (never both high).
REQ-004 SHALL have: ALUOutM  in  32  byte address; WriteDataM  in  32  store data.
REQ-005 SHALL have: hit  out  1  combinational, request serviced this cycle; ReadDataM  out  32  load data.
REQ-006 SHALL have: FillDone  out  1  one-cycle pulse, missed load data valid on ReadDataM; Busy  out  1  controller cannot accept requests.
REQ-007 SHALL have memory side: MemReq  out  1; MemWE  out  1; MemAddr  out  32; MemWData  out  32; MemRData  in  128  whole block; MemReady  in  1  transaction complete.

Function
REQ-008 SHALL be direct-mapped, 16 lines x 4 words: offset ALUOutM[3:2], index ALUOutM[7:4], tag ALUOutM[31:8]; one valid bit per line.
REQ-009 SHALL be write-through, no-write-allocate, with a one-entry write buffer (WBValid, WBAddr, WBData).
REQ-010 SHALL have FSM states IDLE, WAIT_WB, FILL, RESP; Busy = (state != IDLE).
REQ-011 In IDLE, load with valid and tag match: hit=1, ReadDataM = addressed word, same cycle; state stays IDLE.
REQ-012 In IDLE, load miss: hit=0; request address captured; next state FILL.
REQ-013 In IDLE, store with WBValid=0: hit=1; buffer loaded at edge; if line valid and tag match, addressed word updated; else cache untouched.
REQ-014 In IDLE, store with WBValid=1: hit=0; address/data captured; next state WAIT_WB.
REQ-015 WAIT_WB: on the edge where the buffer drains, perform REQ-013 using captured store; return to IDLE; no FillDone.
REQ-016 Buffer drain: whenever WBValid=1, MemReq=1, MemWE=1, MemAddr=WBAddr, MemWData=WBData; WBValid cleared on MemReady edge; drain has priority over refill.
REQ-017 FILL: once WBValid=0, MemReq=1, MemWE=0, MemAddr={captured[31:4],4'b0}, held until MemReady; on MemReady edge line written from MemRData (word i = bits 32i+31:32i), tag stored, valid set; next state RESP.
REQ-018 RESP: FillDone=1 for exactly one cycle, ReadDataM = captured-offset word of filled line; next state IDLE.
REQ-019 When Busy=1, hit=0 and M-stage requests are ignored (not captured).
REQ-020 A store accepted (REQ-013) never bypasses into WBValid test the same cycle: acceptance requires WBValid=0 at the start of that cycle.
REQ-021 MemReq SHALL be 0 when neither drain nor fill is pending; MemAddr/MemWData don't-care then.
REQ-022 hit=0 when no request; ReadDataM = 0 when neither REQ-011 nor REQ-018 applies.

Reset
REQ-023 CLR low SHALL immediately force state IDLE, all valid bits 0, WBValid 0, hit/FillDone/Busy/MemReq/MemWE 0, ReadDataM 0.
REQ-024 Reset mid-FILL or mid-drain SHALL abandon the transaction; a late MemReady after release is ignored in IDLE.
REQ-025 Data/tag arrays need not be reset.

Verification
REQ-026 Reset, load 0x00000104, MemReady high 3 cycles after MemReq rises, MemRData word1=0xCAFEF00D -> hit=0 cycle 0, MemReq cycles 1-4, FillDone=1 cycle 5 with ReadDataM=0xCAFEF00D, Busy low cycle 6.
REQ-027 Repeat load 0x00000104 after REQ-026 -> hit=1, ReadDataM=0xCAFEF00D same cycle, MemReq stays 0.
REQ-028 Store 0x00000104 data 0x12345678 (buffer empty) -> hit=1, MemReq/MemWE=1 next cycle with MemAddr=0x104; following load 0x104 -> hit=1, 0x12345678.
REQ-029 Two back-to-back stores, MemReady delayed 4 cycles -> second hit=0, Busy=1 in WAIT_WB, second write issued after first drains, Busy low after.
REQ-030 Load miss while WBValid=1 -> write transaction completes before any MemWE=0 read; FillDone after read.
REQ-031 CLR pulsed low during FILL -> all outputs 0 immediately; previously filled line then misses.
